// File: rtl/spi_frame_master.sv
// -----------------------------------------------------------------------------
// spi_frame_master
//   SPI mode-0 transmitter. Each accepted request is serialised as one frame
//   F = {cmd, data}, MSB first, onto sclk/ss_n/mosi. All SPI outputs and the
//   status flags are registered.
//
//   Frame sequence (each timed state lasts CLK_DIV clk cycles):
//     IDLE -> SETUP -> HIGH -> LOW -> HIGH ... HIGH -> HOLD -> GAP -> IDLE
//   ss_n is low for (2N+1)*CLK_DIV cycles, with exactly N sclk rising edges.
//
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   i_valid  in   request offered
//   o_ready  out  request accepted on a clk edge when i_valid & o_ready
//   i_cmd    in   [CMD_BITS]  command field (sent first)
//   i_data   in   [DATA_BITS] payload field
//   o_sclk   out  SPI clock, idle low
//   o_ss_n   out  SPI select, active low
//   o_mosi   out  SPI data, changes only while o_sclk is low
//   o_busy   out  high from acceptance until the inter-frame gap ends
//   o_done   out  one-cycle pulse on the cycle ss_n returns high
//
// Configuration macro
//   SPI_FRAME_QUEUE_EN : when defined, a 2-entry FIFO sits ahead of the FSM and
//                        o_ready = !full. When undefined, requests are accepted
//                        only in IDLE and captured straight into the shifter.
// -----------------------------------------------------------------------------
module spi_frame_master #(
  parameter int CLK_DIV    = 4,
  parameter int CMD_BITS   = 4,
  parameter int DATA_BITS  = 6,
  parameter int GAP_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CMD_BITS-1:0]  i_cmd,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_sclk,
  output logic                 o_ss_n,
  output logic                 o_mosi,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int N     = CMD_BITS + DATA_BITS;
  localparam int BIT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(N - 1);
  localparam logic [7:0]       DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0]       GAP_RELOAD = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [N-1:0]     shift_q, shift_d;

  logic sclk_q, sclk_d;
  logic ss_n_q, ss_n_d;
  logic mosi_q, mosi_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Frame start request and the word that frame will carry.
  logic         start_s;
  logic [N-1:0] start_word_s;

`ifdef SPI_FRAME_QUEUE_EN
  logic [N-1:0] fifo_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push_s;
  logic         pop_s;

  assign o_ready      = (count_q != 2'd2) & ~reset;
  assign push_s       = i_valid & o_ready;
  assign start_s      = (state_q == ST_IDLE) && (count_q != 2'd0);
  assign pop_s        = start_s;
  assign start_word_s = fifo_q[rd_ptr_q];

  // FIFO storage: written on push, contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= {i_cmd, i_data};
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_s) wr_ptr_q <= ~wr_ptr_q;
      if (pop_s)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  assign o_ready      = (state_q == ST_IDLE) & ~reset;
  assign start_s      = i_valid & o_ready;
  assign start_word_s = {i_cmd, i_data};
`endif

  // State, counters, shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: the divider reloads on every state entry, otherwise counts down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_SETUP;
          cnt_d   = DIV_RELOAD;
          bit_d   = '0;
          shift_d = start_word_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP, ST_LOW: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_HIGH;
          cnt_d   = DIV_RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == 8'd0) begin
          cnt_d = DIV_RELOAD;
          if (bit_q == LAST_BIT) begin
            state_d = ST_HOLD;
          end else begin
            // Next bit moves to the shifter MSB, presented while sclk is low.
            state_d = ST_LOW;
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q << 1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output decode from the next state so the registered pins line up with it.
  always_comb begin
    sclk_d = 1'b0;
    ss_n_d = 1'b1;
    mosi_d = 1'b0;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_SETUP, ST_LOW, ST_HOLD: begin
        ss_n_d = 1'b0;
        mosi_d = shift_d[N-1];
      end
      ST_HIGH: begin
        ss_n_d = 1'b0;
        sclk_d = 1'b1;
        mosi_d = shift_d[N-1];
      end
      ST_GAP: begin
        done_d = (state_q == ST_HOLD);
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign o_sclk = sclk_q;
  assign o_ss_n = ss_n_q;
  assign o_mosi = mosi_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
